// File: rtl/mem_axil_bridge.sv
// Merged single-port memory request -> one AXI4-Lite master transaction at a time.
// Optional MEM_AXIL_BRIDGE_ERR_EN adds sticky error reporting (err_o/err_addr_o/err_clr_i).
module mem_axil_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mem_rd_i,
    input  logic                mem_wr_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_data_i,
    output logic                mem_ready_o,
    output logic [DATA_W-1:0]   mem_data_o,
    output logic [ADDR_W-1:0]   m_axi_awaddr_o,
    output logic                m_axi_awvalid_o,
    input  logic                m_axi_awready_i,
    output logic [2:0]          m_axi_awprot_o,
    output logic [DATA_W-1:0]   m_axi_wdata_o,
    output logic [DATA_W/8-1:0] m_axi_wstrb_o,
    output logic                m_axi_wvalid_o,
    input  logic                m_axi_wready_i,
    input  logic [1:0]          m_axi_bresp_i,
    input  logic                m_axi_bvalid_i,
    output logic                m_axi_bready_o,
    output logic [ADDR_W-1:0]   m_axi_araddr_o,
    output logic                m_axi_arvalid_o,
    input  logic                m_axi_arready_i,
    output logic [2:0]          m_axi_arprot_o,
    input  logic [DATA_W-1:0]   m_axi_rdata_i,
    input  logic [1:0]          m_axi_rresp_i,
    input  logic                m_axi_rvalid_i,
    output logic                m_axi_rready_o
`ifdef MEM_AXIL_BRIDGE_ERR_EN
    ,
    output logic                err_o,
    output logic [ADDR_W-1:0]   err_addr_o,
    input  logic                err_clr_i
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              aw_fin;
    logic              w_fin;
    logic              rd_err;

    // A channel counts as finished once its valid has already dropped or is handshaking now.
    assign aw_fin = !m_axi_awvalid_o || m_axi_awready_i;
    assign w_fin  = !m_axi_wvalid_o  || m_axi_wready_i;

    assign m_axi_awaddr_o = addr_q;
    assign m_axi_araddr_o = addr_q;
    assign m_axi_wdata_o  = wdata_q;
    assign m_axi_wstrb_o  = '1;
    assign m_axi_awprot_o = '0;
    assign m_axi_arprot_o = '0;

`ifdef MEM_AXIL_BRIDGE_ERR_EN
    logic wr_err;
    logic new_err;

    assign rd_err  = (state == RD_DATA) && m_axi_rvalid_i && (m_axi_rresp_i != 2'b00);
    assign wr_err  = (state == WR_RESP) && m_axi_bvalid_i && (m_axi_bresp_i != 2'b00);
    assign new_err = rd_err || wr_err;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else if (new_err) begin
            err_o <= 1'b1;
            if (!err_o) begin
                err_addr_o <= addr_q;
            end
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end
    end
`else
    logic unused_resp;

    assign rd_err      = 1'b0;
    assign unused_resp = ^{m_axi_rresp_i, m_axi_bresp_i};
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state           <= IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            mem_ready_o     <= 1'b0;
            mem_data_o      <= '0;
            m_axi_awvalid_o <= 1'b0;
            m_axi_wvalid_o  <= 1'b0;
            m_axi_bready_o  <= 1'b0;
            m_axi_arvalid_o <= 1'b0;
            m_axi_rready_o  <= 1'b0;
        end else begin
            mem_ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_wr_i) begin
                        addr_q          <= mem_addr_i;
                        wdata_q         <= mem_data_i;
                        m_axi_awvalid_o <= 1'b1;
                        m_axi_wvalid_o  <= 1'b1;
                        state           <= WR_REQ;
                    end else if (mem_rd_i) begin
                        addr_q          <= mem_addr_i;
                        m_axi_arvalid_o <= 1'b1;
                        state           <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (m_axi_arready_i) begin
                        m_axi_arvalid_o <= 1'b0;
                        m_axi_rready_o  <= 1'b1;
                        state           <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid_i) begin
                        m_axi_rready_o <= 1'b0;
                        mem_data_o     <= rd_err ? '0 : m_axi_rdata_i;
                        mem_ready_o    <= 1'b1;
                        state          <= DONE;
                    end
                end
                WR_REQ: begin
                    if (aw_fin && w_fin) begin
                        m_axi_awvalid_o <= 1'b0;
                        m_axi_wvalid_o  <= 1'b0;
                        m_axi_bready_o  <= 1'b1;
                        state           <= WR_RESP;
                    end else begin
                        if (m_axi_awready_i) m_axi_awvalid_o <= 1'b0;
                        if (m_axi_wready_i)  m_axi_wvalid_o  <= 1'b0;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid_i) begin
                        m_axi_bready_o <= 1'b0;
                        mem_ready_o    <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_axil_bridge.sv
// Bench for mem_axil_bridge: vector table, delay-configurable AXI-Lite slave, scoreboard queues.
module tb_mem_axil_bridge;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        mem_rd_i = 1'b0, mem_wr_i = 1'b0;
    logic [31:0] mem_addr_i = '0, mem_data_i = '0;
    logic        mem_ready_o;
    logic [31:0] mem_data_o;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic [1:0]  bresp, rresp;
`ifdef MEM_AXIL_BRIDGE_ERR_EN
    logic        err_o;
    logic [31:0] err_addr_o;
    logic        err_clr_i = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_axil_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .mem_ready_o(mem_ready_o), .mem_data_o(mem_data_o),
        .m_axi_awaddr_o(awaddr), .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
        .m_axi_awprot_o(awprot),
        .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
        .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready),
        .m_axi_araddr_o(araddr), .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
        .m_axi_arprot_o(arprot),
        .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready)
`ifdef MEM_AXIL_BRIDGE_ERR_EN
        , .err_o(err_o), .err_addr_o(err_addr_o), .err_clr_i(err_clr_i)
`endif
    );

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wdata, rdata;
        logic [1:0]  resp;
        int          aw_dly, w_dly, ar_dly, r_dly, b_dly;
        int          cycles, aw_len, w_len;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr, data;
    } axi_t;

    axi_t        exp_axi[$];
    logic [31:0] exp_rsp[$];
    logic [31:0] model_data = '0;
    int          checks = 0, errors = 0;

    int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0, cfg_b_dly = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_resp = '0;
    logic [31:0] obs_awaddr = '0, obs_wdata = '0;
    logic [3:0]  obs_wstrb = '0;
    int          obs_aw_len = 0, obs_w_len = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", nm);
    endtask

    task automatic sb_axi(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        axi_t e;
        if (exp_axi.size() == 0) begin
            fail_now(wr ? "unexpected_write" : "unexpected_read");
        end else begin
            e = exp_axi.pop_front();
            check("axi_kind", {31'd0, wr}, {31'd0, e.wr});
            check("axi_addr", addr, e.addr);
            if (wr) begin
                check("axi_wdata", data, e.data);
                check("axi_wstrb", {28'd0, obs_wstrb}, 32'h0000_000F);
            end
        end
    endtask

    // AXI-Lite slave: each ready/valid response appears after a configurable number of cycles.
    initial begin
        int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
        {arready, awready, wready, rvalid, bvalid} = '0;
        rdata = '0; rresp = '0; bresp = '0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                {arready, awready, wready, rvalid, bvalid} = '0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
            end else begin
                arready = arvalid && (ar_cnt >= cfg_ar_dly);
                if (arready) sb_axi(1'b0, araddr, '0);
                ar_cnt = (arvalid && !arready) ? ar_cnt + 1 : 0;

                awready = awvalid && (aw_cnt >= cfg_aw_dly);
                if (awready) begin obs_awaddr = awaddr; obs_aw_len = aw_cnt + 1; end
                aw_cnt = (awvalid && !awready) ? aw_cnt + 1 : 0;

                wready = wvalid && (w_cnt >= cfg_w_dly);
                if (wready) begin obs_wdata = wdata; obs_wstrb = wstrb; obs_w_len = w_cnt + 1; end
                w_cnt = (wvalid && !wready) ? w_cnt + 1 : 0;

                rvalid = rready && (r_cnt >= cfg_r_dly);
                rdata  = cfg_rdata;
                rresp  = cfg_resp;
                r_cnt  = (rready && !rvalid) ? r_cnt + 1 : 0;

                bvalid = bready && (b_cnt >= cfg_b_dly);
                bresp  = cfg_resp;
                if (bvalid) sb_axi(1'b1, obs_awaddr, obs_wdata);
                b_cnt  = (bready && !bvalid) ? b_cnt + 1 : 0;
            end
        end
    end

    // Completion monitor: every ready pulse must match the next expected read-data value.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_ready_o) begin
                if (exp_rsp.size() == 0) fail_now("unexpected_ready");
                else check("mem_data_o", mem_data_o, exp_rsp.pop_front());
            end
        end
    end

    function automatic vec_t mkv(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rd_data, input logic [1:0] resp,
                                 input int aw_d, input int w_d, input int ar_d, input int r_d, input int b_d,
                                 input int cyc, input int aw_l, input int w_l);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wd; v.rdata = rd_data; v.resp = resp;
        v.aw_dly = aw_d; v.w_dly = w_d; v.ar_dly = ar_d; v.r_dly = r_d; v.b_dly = b_d;
        v.cycles = cyc; v.aw_len = aw_l; v.w_len = w_l;
        return v;
    endfunction

    // Starts and ends at a negedge in IDLE; the next call presents its request the cycle after DONE.
    task automatic run_vec(input vec_t v);
        axi_t e;
        int   n;
        bit   seen;
        cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_ar_dly = v.ar_dly;
        cfg_r_dly = v.r_dly; cfg_b_dly = v.b_dly; cfg_rdata = v.rdata; cfg_resp = v.resp;
        e.wr = v.wr; e.addr = v.addr; e.data = v.wr ? v.wdata : '0;
        exp_axi.push_back(e);
        if (!v.wr) begin
            model_data = v.rdata;
`ifdef MEM_AXIL_BRIDGE_ERR_EN
            if (v.resp != 2'b00) model_data = '0;
`endif
        end
        exp_rsp.push_back(model_data);
        mem_rd_i = v.rd; mem_wr_i = v.wr; mem_addr_i = v.addr; mem_data_i = v.wdata;
        n = 0;
        seen = 0;
        while (!seen && n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = mem_ready_o;
        end
        mem_rd_i = 1'b0; mem_wr_i = 1'b0;
        check("ready_seen", {31'd0, seen}, 32'd1);
        check("latency", n, v.cycles);
        if (v.wr) begin
            check("awvalid_len", obs_aw_len, v.aw_len);
            check("wvalid_len", obs_w_len, v.w_len);
        end
        @(posedge clk);
        @(negedge clk);
        check("ready_single", {31'd0, mem_ready_o}, 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int n;
        //               rd  wr  addr          wdata         rdata         rsp  aw w ar r b  cyc awl wl
        vecs[0] = mkv(1, 0, 32'h0000_0010, 32'h0,        32'hCAFE_F00D, 0,  0, 0, 0, 0, 0, 3, 0, 0);
        vecs[1] = mkv(0, 1, 32'h2000_0004, 32'h1234_5678, 32'h0,       0,  0, 3, 0, 0, 0, 6, 1, 4);
        vecs[2] = mkv(1, 1, 32'h0000_0030, 32'hA5A5_5A5A, 32'h7777_7777, 0, 0, 0, 0, 0, 0, 3, 1, 1);
        vecs[3] = mkv(0, 1, 32'h0000_0100, 32'h1111_2222, 32'h0,       0,  0, 0, 0, 0, 0, 3, 1, 1);
        vecs[4] = mkv(1, 0, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 0,  0, 0, 0, 0, 0, 3, 0, 0);
        vecs[5] = mkv(1, 0, 32'h0000_0200, 32'h0,        32'h0BAD_CAFE, 0,  0, 0, 2, 1, 0, 6, 0, 0);
        vecs[6] = mkv(0, 1, 32'h0000_0300, 32'h0F0F_F0F0, 32'h0,       0,  2, 0, 0, 0, 2, 7, 3, 1);

        #2 rst_i = 1'b0;
        #1;
        check("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("rst_awvalid", {31'd0, awvalid}, 32'd0);
        check("rst_wvalid", {31'd0, wvalid}, 32'd0);
        check("rst_ready", {31'd0, mem_ready_o}, 32'd0);
        check("rst_data", mem_data_o, 32'd0);
        check("rst_araddr", araddr, 32'd0);
`ifdef MEM_AXIL_BRIDGE_ERR_EN
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_err_addr", err_addr_o, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);

        for (int unsigned i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset while waiting in RD_DATA abandons the read outright.
        cfg_r_dly = 20; cfg_ar_dly = 0;
        exp_axi.push_back('{wr: 1'b0, addr: 32'h0000_0050, data: 32'h0});
        mem_rd_i = 1'b1; mem_addr_i = 32'h0000_0050;
        n = 0;
        while (!rready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rready_reached", {31'd0, rready}, 32'd1);
        rst_i = 1'b0;
        #1;
        check("midrst_arvalid", {31'd0, arvalid}, 32'd0);
        check("midrst_rready", {31'd0, rready}, 32'd0);
        check("midrst_ready", {31'd0, mem_ready_o}, 32'd0);
        check("midrst_data", mem_data_o, 32'd0);
        mem_rd_i = 1'b0;
        model_data = '0;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        run_vec(mkv(1, 0, 32'h0000_0008, 32'h0, 32'h8888_0008, 0, 0, 0, 0, 0, 0, 3, 0, 0));

`ifdef MEM_AXIL_BRIDGE_ERR_EN
        run_vec(mkv(1, 0, 32'h4000_0000, 32'h0, 32'h5555_AAAA, 2'b10, 0, 0, 0, 0, 0, 3, 0, 0));
        check("err_set", {31'd0, err_o}, 32'd1);
        check("err_addr_first", err_addr_o, 32'h4000_0000);
        run_vec(mkv(1, 0, 32'h4000_0004, 32'h0, 32'h6666_BBBB, 2'b10, 0, 0, 0, 0, 0, 3, 0, 0));
        check("err_addr_kept", err_addr_o, 32'h4000_0000);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        check("err_cleared", {31'd0, err_o}, 32'd0);
        run_vec(mkv(0, 1, 32'h0000_0500, 32'h0000_0BAD, 32'h0, 2'b11, 0, 0, 0, 0, 0, 3, 1, 1));
        check("err_wr_set", {31'd0, err_o}, 32'd1);
        check("err_wr_addr", err_addr_o, 32'h0000_0500);
        run_vec(mkv(1, 0, 32'h0000_0600, 32'h0, 32'h1357_9BDF, 0, 0, 0, 0, 0, 0, 3, 0, 0));
`endif

        repeat (3) @(negedge clk);
        check("axi_queue_empty", exp_axi.size(), 32'd0);
        check("rsp_queue_empty", exp_rsp.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
